// File: rtl/wb_multilane_stage_pkg.sv
// Shared core types for the writeback stage: packet structs, sizes and the
// modular seqNo age compare (also used by the issue queue).
package wb_multilane_stage_pkg;

    localparam int SIZE_SEQ      = 8;
    localparam int SIZE_AL       = 6;
    localparam int SIZE_LOG      = 5;
    localparam int SIZE_PHY      = 7;
    localparam int SIZE_DATA     = 32;
    localparam int SIZE_PC       = 32;
    localparam int SIZE_FLAGS    = 8;
    localparam int WB_CTRL_DELAY = 2;

    typedef struct packed {
        logic [SIZE_SEQ-1:0]   seqNo;
        logic                  valid;
        logic [SIZE_AL-1:0]    alID;
        logic [SIZE_FLAGS-1:0] flags;
        logic [SIZE_LOG-1:0]   logDest;
        logic [SIZE_PHY-1:0]   phyDest;
        logic [SIZE_DATA-1:0]  destData;
    } wbPkt;

    localparam int WB_PKT_SIZE = $bits(wbPkt);

    typedef struct packed {
        logic [SIZE_SEQ-1:0]   seqNo;
        logic                  valid;
        logic [SIZE_AL-1:0]    alID;
        logic [SIZE_FLAGS-1:0] flags;
        logic [SIZE_PC-1:0]    nextPC;
        logic                  actualDir;
    } ctrlPkt;

    typedef struct packed {
        logic [SIZE_LOG-1:0]  logDest;
        logic [SIZE_PHY-1:0]  tag;
        logic [SIZE_DATA-1:0] data;
        logic                 valid;
    } bypassPkt;

    // a is younger than b when (a - b) mod 2^w is nonzero with a clear sign bit.
    function automatic logic seq_younger(input logic [SIZE_SEQ-1:0] a,
                                         input logic [SIZE_SEQ-1:0] b,
                                         input int w);
        logic [SIZE_SEQ-1:0] d;
        logic [SIZE_SEQ-1:0] msk;
        logic [SIZE_SEQ-1:0] sh;
        msk = ~({SIZE_SEQ{1'b1}} << w);
        d   = (a - b) & msk;
        sh  = d >> (w - 1);
        return (d != '0) && (sh[0] == 1'b0);
    endfunction

endpackage

// File: rtl/wb_lane_pipe.sv
// One writeback lane: CTRL_DELAY packet stages with selective (age based)
// squash on recovery and a full flush.
module wb_lane_pipe
    import wb_multilane_stage_pkg::*;
#(
    parameter int CTRL_DELAY = WB_CTRL_DELAY,
    parameter int SEQ_W      = SIZE_SEQ
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                i_en,
    input  wbPkt                i_pkt,
    input  logic                i_recover,
    input  logic [SIZE_SEQ-1:0] i_recSeq,
    input  logic                i_flush,
    output wbPkt                o_s0,
    output wbPkt                o_last
);

    wbPkt                  r_stage [CTRL_DELAY];
    wbPkt                  w_src   [CTRL_DELAY];
    logic [CTRL_DELAY-1:0] w_kill;

    // w_src[k] is what stage k would load; the entry leaving the last stage
    // is never squashed because its output is already on the wires.
    always_comb begin
        w_src[0] = (i_en && i_pkt.valid) ? i_pkt : '0;
        for (int k = 1; k < CTRL_DELAY; k++) begin
            w_src[k] = r_stage[k-1];
        end
        w_kill = '0;
        if (i_recover) begin
            for (int k = 0; k < CTRL_DELAY; k++) begin
                w_kill[k] = seq_younger(w_src[k].seqNo, i_recSeq, SEQ_W);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < CTRL_DELAY; k++) r_stage[k] <= '0;
        end else if (i_flush) begin
            for (int k = 0; k < CTRL_DELAY; k++) r_stage[k] <= '0;
        end else begin
            for (int k = 0; k < CTRL_DELAY; k++) begin
                r_stage[k] <= w_kill[k] ? '0 : w_src[k];
            end
        end
    end

    assign o_s0   = r_stage[0];
    assign o_last = r_stage[CTRL_DELAY-1];

endmodule

// File: rtl/wb_multilane_stage.sv
// Multi-lane writeback stage: per-lane stage pipes, bypass/ctrl packet
// formatting and a saturating count of emitted completions.
module wb_multilane_stage
    import wb_multilane_stage_pkg::*;
#(
    parameter int NUM_LANES  = 4,
    parameter int CTRL_DELAY = WB_CTRL_DELAY,
    parameter int SEQ_W      = SIZE_SEQ
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            recoverFlag_i,
    input  logic [SEQ_W-1:0]                recoverSeqNo_i,
    input  logic                            fullFlush_i,
    input  logic [NUM_LANES-1:0]            laneEnable_i,
    input  wbPkt     [NUM_LANES-1:0]        wbPacket_i,
    output ctrlPkt   [NUM_LANES-1:0]        ctrlPacket_o,
    output bypassPkt [NUM_LANES-1:0]        bypassPacket_o,
    output logic [31:0]                     wbCount_o
);

    localparam int CNT_W = $clog2(NUM_LANES + 1);

    logic [SIZE_SEQ-1:0]   w_recSeq;
    wbPkt [NUM_LANES-1:0]  w_s0;
    wbPkt [NUM_LANES-1:0]  w_last;
    logic [CNT_W-1:0]      w_pop;
    logic [32:0]           w_sum;
    logic [31:0]           r_wbCount;

    always_comb begin
        w_recSeq              = '0;
        w_recSeq[SEQ_W-1:0]   = recoverSeqNo_i;
    end

    for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
        wb_lane_pipe #(
            .CTRL_DELAY (CTRL_DELAY),
            .SEQ_W      (SEQ_W)
        ) u_lane (
            .clk       (clk),
            .reset     (reset),
            .i_en      (laneEnable_i[l]),
            .i_pkt     (wbPacket_i[l]),
            .i_recover (recoverFlag_i),
            .i_recSeq  (w_recSeq),
            .i_flush   (fullFlush_i),
            .o_s0      (w_s0[l]),
            .o_last    (w_last[l])
        );
    end

    always_comb begin
        w_pop = '0;
        for (int l = 0; l < NUM_LANES; l++) begin
            bypassPacket_o[l].logDest = w_s0[l].logDest;
            bypassPacket_o[l].tag     = w_s0[l].phyDest;
            bypassPacket_o[l].data    = w_s0[l].destData;
            bypassPacket_o[l].valid   = w_s0[l].valid & w_s0[l].flags[4];

            ctrlPacket_o[l].seqNo     = w_last[l].seqNo;
            ctrlPacket_o[l].valid     = w_last[l].valid;
            ctrlPacket_o[l].alID      = w_last[l].alID;
            ctrlPacket_o[l].flags     = w_last[l].flags;
            ctrlPacket_o[l].nextPC    = '0;
            ctrlPacket_o[l].actualDir = 1'b0;

            w_pop = w_pop + CNT_W'(w_last[l].valid);
        end
    end

    // One extra carry bit detects overflow so the count pins at all-ones.
    assign w_sum = {1'b0, r_wbCount} + 33'(w_pop);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_wbCount <= '0;
        else       r_wbCount <= w_sum[32] ? 32'hFFFF_FFFF : w_sum[31:0];
    end

    assign wbCount_o = r_wbCount;

endmodule

// File: tb/tb_wb_multilane_stage.sv
// Randomized and directed bench for wb_multilane_stage against a queue-based
// model of in-flight packets tagged with their age in the pipe.
module tb_wb_multilane_stage;
    import wb_multilane_stage_pkg::*;

    localparam int NL = 4;
    localparam int CD = 2;
    localparam int SW = 8;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 rec;
    logic [SW-1:0]        rec_seq;
    logic                 flush;
    logic [NL-1:0]        in_en;
    wbPkt     [NL-1:0]    in_pkt;
    ctrlPkt   [NL-1:0]    ctrl;
    bypassPkt [NL-1:0]    byp;
    logic [31:0]          cnt;

    always #5 clk = ~clk;

    wb_multilane_stage #(.NUM_LANES(NL), .CTRL_DELAY(CD), .SEQ_W(SW)) dut (
        .clk            (clk),
        .reset          (reset),
        .recoverFlag_i  (rec),
        .recoverSeqNo_i (rec_seq),
        .fullFlush_i    (flush),
        .laneEnable_i   (in_en),
        .wbPacket_i     (in_pkt),
        .ctrlPacket_o   (ctrl),
        .bypassPacket_o (byp),
        .wbCount_o      (cnt)
    );

    typedef struct {
        int   lane;
        wbPkt p;
        int   age;
    } ent_t;

    ent_t   q[$];
    longint exp_cnt;
    int     n_chk  = 0;
    int     n_pass = 0;
    int     seq_ctr = 0;
    longint c0;

    task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    endtask

    function automatic bit m_younger(input int s, input int r);
        int d;
        d = (s - r) % 256;
        if (d < 0) d += 256;
        return (d > 0) && (d < 128);
    endfunction

    function automatic wbPkt mk(input int seq, input int phy, input logic [31:0] data, input bit f4);
        wbPkt p;
        p          = '0;
        p.valid    = 1'b1;
        p.seqNo    = 8'(seq);
        p.phyDest  = 7'(phy);
        p.destData = data;
        p.logDest  = 5'($urandom_range(0, 31));
        p.alID     = 6'($urandom_range(0, 63));
        p.flags    = 8'($urandom_range(0, 255));
        p.flags[4] = f4;
        return p;
    endfunction

    task automatic idle_inputs();
        rec = 1'b0; rec_seq = '0; flush = 1'b0; in_en = '0; in_pkt = '0;
    endtask

    // Apply the inputs present now to the model for the coming edge.
    task automatic model_step();
        ent_t nq[$];
        ent_t e;
        longint pop = 0;
        foreach (q[i]) if (q[i].age == CD - 1) pop++;
        exp_cnt += pop;
        if (exp_cnt > 64'hFFFF_FFFF) exp_cnt = 64'hFFFF_FFFF;
        if (!flush) begin
            foreach (q[i]) begin
                if (q[i].age < CD - 1 && !(rec && m_younger(int'(q[i].p.seqNo), int'(rec_seq)))) begin
                    e = q[i]; e.age++; nq.push_back(e);
                end
            end
            for (int l = 0; l < NL; l++) begin
                if (in_en[l] && in_pkt[l].valid &&
                    !(rec && m_younger(int'(in_pkt[l].seqNo), int'(rec_seq)))) begin
                    e.lane = l; e.p = in_pkt[l]; e.age = 0; nq.push_back(e);
                end
            end
        end
        q = nq;
    endtask

    task automatic check_outputs();
        ctrlPkt   ec;
        bypassPkt eb;
        for (int l = 0; l < NL; l++) begin
            ec = '0; eb = '0;
            foreach (q[i]) begin
                if (q[i].lane == l && q[i].age == 0) begin
                    eb.logDest = q[i].p.logDest;
                    eb.tag     = q[i].p.phyDest;
                    eb.data    = q[i].p.destData;
                    eb.valid   = q[i].p.flags[4];
                end
                if (q[i].lane == l && q[i].age == CD - 1) begin
                    ec.seqNo = q[i].p.seqNo;
                    ec.valid = 1'b1;
                    ec.alID  = q[i].p.alID;
                    ec.flags = q[i].p.flags;
                end
            end
            chk($sformatf("ctrl%0d", l), 128'(ctrl[l]), 128'(ec));
            chk($sformatf("byp%0d", l), 128'(byp[l]), 128'(eb));
        end
        chk("wbCount", 128'(cnt), 128'(exp_cnt));
    endtask

    task automatic cyc();
        model_step();
        @(posedge clk);
        @(negedge clk);
        check_outputs();
    endtask

    initial begin
        idle_inputs();
        reset = 1'b1; exp_cnt = 0; q.delete();
        #12;
        @(negedge clk); reset = 1'b0;
        check_outputs();
        repeat (10) cyc();
        chk("idle_cnt", 128'(cnt), 128'(0));

        // Single packet latency, bypass enabled
        in_en = '1; in_pkt[2] = mk(5, 17, 32'hDEADBEEF, 1'b1);
        cyc();
        chk("byp_valid", 128'(byp[2].valid), 128'(1));
        chk("byp_tag",   128'(byp[2].tag),   128'(17));
        chk("byp_data",  128'(byp[2].data),  128'(32'hDEADBEEF));
        chk("ctrl_early", 128'(ctrl[2].valid), 128'(0));
        idle_inputs(); cyc();
        chk("ctrl_valid", 128'(ctrl[2].valid), 128'(1));
        chk("ctrl_seq",   128'(ctrl[2].seqNo), 128'(5));
        cyc();
        chk("cnt_one", 128'(cnt), 128'(1));

        // flags[4] clear: no bypass, completion still reported
        in_en = '1; in_pkt[2] = mk(5, 17, 32'hDEADBEEF, 1'b0);
        cyc();
        chk("nobyp_valid", 128'(byp[2].valid), 128'(0));
        idle_inputs(); cyc();
        chk("nobyp_ctrl", 128'(ctrl[2].valid), 128'(1));
        cyc();
        chk("cnt_two", 128'(cnt), 128'(2));

        // Selective squash across seqNo wrap
        in_en = '1;
        in_pkt[0] = mk(250, 1, 32'h250, 1'b1);
        in_pkt[1] = mk(254, 2, 32'h254, 1'b1);
        in_pkt[2] = mk(3,   3, 32'h3,   1'b1);
        cyc();
        in_pkt = '0; in_en = '1;
        in_pkt[0] = mk(252, 4, 32'h252, 1'b1);
        in_pkt[3] = mk(4,   5, 32'h4,   1'b1);
        rec = 1'b1; rec_seq = 8'd252;
        cyc();
        chk("sq_250_valid", 128'(ctrl[0].valid), 128'(1));
        chk("sq_250_seq",   128'(ctrl[0].seqNo), 128'(250));
        chk("sq_254",       128'(ctrl[1].valid), 128'(0));
        chk("sq_3",         128'(ctrl[2].valid), 128'(0));
        chk("sq_in4",       128'(byp[3].valid),  128'(0));
        chk("sq_in252_byp", 128'(byp[0].valid),  128'(1));
        idle_inputs(); cyc();
        chk("sq_in252_ctrl", 128'(ctrl[0].seqNo), 128'(252));
        chk("sq_in4_ctrl",   128'(ctrl[3].valid), 128'(0));
        cyc();

        // Full flush wins over recover
        in_en = '1;
        for (int l = 0; l < NL; l++) in_pkt[l] = mk(10 + l, l, 32'(l), 1'b1);
        cyc();
        for (int l = 0; l < NL; l++) in_pkt[l] = mk(20 + l, l, 32'(l), 1'b1);
        cyc();
        for (int l = 0; l < NL; l++) in_pkt[l] = mk(30 + l, l, 32'(l), 1'b1);
        flush = 1'b1; rec = 1'b1; rec_seq = 8'd0;
        cyc();
        c0 = exp_cnt;
        for (int l = 0; l < NL; l++) begin
            chk($sformatf("fl_ctrl%0d", l), 128'(ctrl[l].valid), 128'(0));
            chk($sformatf("fl_byp%0d", l),  128'(byp[l].valid),  128'(0));
        end
        idle_inputs();
        repeat (3) cyc();
        chk("fl_cnt_frozen", 128'(cnt), 128'(c0));

        // Counter saturation
        force dut.r_wbCount = 32'hFFFF_FFFE;
        #1 release dut.r_wbCount;
        exp_cnt = 64'hFFFF_FFFE;
        in_en = '1;
        for (int l = 0; l < NL; l++) in_pkt[l] = mk(40 + l, l, 32'(l), 1'b1);
        cyc();
        idle_inputs();
        cyc(); cyc();
        chk("sat_cnt", 128'(cnt), 128'(32'hFFFF_FFFF));
        cyc(); cyc();
        chk("sat_hold", 128'(cnt), 128'(32'hFFFF_FFFF));

        // Reset mid-stream drops everything in flight
        in_en = '1;
        for (int l = 0; l < NL; l++) in_pkt[l] = mk(50 + l, l, 32'(l), 1'b1);
        model_step();
        @(posedge clk);
        #2 reset = 1'b1; q.delete(); exp_cnt = 0;
        @(negedge clk);
        check_outputs();
        idle_inputs();
        @(negedge clk); reset = 1'b0;
        check_outputs();
        cyc();
        chk("rst_cnt", 128'(cnt), 128'(0));

        // Lane enable mask
        in_en = 4'b1011;
        for (int l = 0; l < NL; l++) in_pkt[l] = mk(60 + l, l, 32'(l), 1'b1);
        cyc();
        idle_inputs(); cyc();
        chk("en_lane2", 128'(ctrl[2].valid), 128'(0));
        chk("en_lane3", 128'(ctrl[3].valid), 128'(1));
        cyc();
        chk("en_cnt", 128'(cnt), 128'(3));

        // Random traffic with recoveries, flushes and seqNo wrap
        seq_ctr = 100;
        for (int c = 0; c < 400; c++) begin
            idle_inputs();
            for (int l = 0; l < NL; l++) begin
                in_en[l] = ($urandom_range(0, 7) != 0);
                if ($urandom_range(0, 9) < 7) begin
                    in_pkt[l] = mk(seq_ctr % 256, $urandom_range(0, 127), $urandom, 1'($urandom_range(0, 1)));
                    seq_ctr++;
                end else begin
                    in_pkt[l] = '0;
                    in_pkt[l].seqNo = 8'($urandom_range(0, 255));
                end
            end
            if ($urandom_range(0, 7) == 0) begin
                rec = 1'b1;
                rec_seq = 8'((seq_ctr - $urandom_range(0, 8)) % 256);
            end
            flush = ($urandom_range(0, 39) == 0);
            cyc();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running expected done");
        $fatal(1);
    end

endmodule
